// File: rtl/lcd_driver_alarm_n_if.sv
// Signal bundle between timekeeping/keypad logic and the alarm-clock LCD driver.
// master drives the time sources and controls; slave is the driver itself.
interface lcd_driver_alarm_n_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  tick;
  logic [4*DIGITS-1:0]   alarm_time;
  logic [4*DIGITS-1:0]   current_time;
  logic [4*DIGITS-1:0]   key_time;
  logic                  show_a;
  logic                  show_current_time;
  logic                  alarm_en;
  logic                  stop_alarm;
  logic                  snooze;
  logic [8*DIGITS-1:0]   display;
  logic                  sound_a;
  logic [1:0]            alarm_state;

  modport master (
    output tick, alarm_time, current_time, key_time, show_a, show_current_time,
    output alarm_en, stop_alarm, snooze,
    input  display, sound_a, alarm_state
  );

  modport slave (
    input  tick, alarm_time, current_time, key_time, show_a, show_current_time,
    input  alarm_en, stop_alarm, snooze,
    output display, sound_a, alarm_state
  );
endinterface

// File: rtl/lcd_driver_alarm_n.sv
// Alarm-clock LCD driver: source select, BCD->ASCII with key-entry blink, and a
// ringing/snooze alarm FSM with tick-driven timeouts.
module lcd_driver_alarm_n #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned RING_TICKS   = 60,
  parameter int unsigned SNOOZE_TICKS = 300,
  parameter int unsigned BLINK_TICKS  = 1
) (
  input logic                 clock,
  input logic                 reset,
  lcd_driver_alarm_n_if.slave bus
);
  localparam int unsigned MaxTicks = (RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);
  localparam int unsigned BlinkW   = $clog2(BLINK_TICKS + 1);

  typedef enum logic [1:0] {StIdle = 2'b00, StRing = 2'b01, StSnooze = 2'b10} state_e;

  function automatic logic [7:0] enc(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h45;
  endfunction

  logic [4*DIGITS-1:0] src;
  logic                key_mode;
  logic [8*DIGITS-1:0] display_d, display_q;
  logic [BlinkW-1:0]   blink_cnt_d, blink_cnt_q;
  logic                blink_d, blink_q;
  logic                match, match_q;
  state_e              state_d, state_q;
  logic [CntW-1:0]     cnt_d, cnt_q;
  logic                sound_q;

  assign key_mode = ~bus.show_a & ~bus.show_current_time;
  assign match    = (bus.current_time == bus.alarm_time);

  always_comb begin
    src = bus.key_time;
    if (bus.show_a)                 src = bus.alarm_time;
    else if (bus.show_current_time) src = bus.current_time;
  end

  always_comb begin
    display_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      display_d[8*i +: 8] = (key_mode && blink_q) ? 8'h20 : enc(src[4*i +: 4]);
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (!key_mode) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (bus.tick) begin
      if (blink_cnt_q == BlinkW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end
  end

  // Entering any state zeroes the counter, so a tick on a transition cycle is never counted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.alarm_en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (match && !match_q) begin
            state_d = StRing;
            cnt_d   = '0;
          end
        end
        StRing: begin
          if (bus.stop_alarm) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (bus.snooze) begin
            state_d = StSnooze;
            cnt_d   = '0;
          end else if (bus.tick) begin
            if (cnt_q == CntW'(RING_TICKS - 1)) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StSnooze: begin
          if (bus.stop_alarm) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (bus.tick) begin
            if (cnt_q == CntW'(SNOOZE_TICKS - 1)) begin
              state_d = StRing;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      display_q   <= {DIGITS{8'h20}};
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      match_q     <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      sound_q     <= 1'b0;
    end else begin
      display_q   <= display_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      match_q     <= match;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sound_q     <= (state_d == StRing);
    end
  end

  assign bus.display     = display_q;
  assign bus.sound_a     = sound_q;
  assign bus.alarm_state = state_q;
endmodule

// File: tb/tb_lcd_driver_alarm_n.sv
// Directed bench for lcd_driver_alarm_n: display vector table plus blink and
// alarm FSM sequences with hand-computed expectations.
module tb_lcd_driver_alarm_n;
  logic clock = 1'b0;
  logic reset;

  lcd_driver_alarm_n_if #(.DIGITS(4)) bus ();

  lcd_driver_alarm_n #(
    .DIGITS      (4),
    .RING_TICKS  (4),
    .SNOOZE_TICKS(3),
    .BLINK_TICKS (2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        show_a;
    logic        show_cur;
    logic [15:0] alarm;
    logic [15:0] current;
    logic [15:0] key;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    step();
  endtask

  task automatic check_disp(input string name, input logic [31:0] exp);
    n_tests++;
    if (bus.display !== exp) begin
      n_fail++;
      $display("FAIL %s: display=%h expected %h", name, bus.display, exp);
    end
  endtask

  task automatic check_alarm(input string name, input logic exp_sound, input logic [1:0] exp_st);
    n_tests++;
    if (bus.sound_a !== exp_sound || bus.alarm_state !== exp_st) begin
      n_fail++;
      $display("FAIL %s: sound_a=%b alarm_state=%b expected sound_a=%b alarm_state=%b",
               name, bus.sound_a, bus.alarm_state, exp_sound, exp_st);
    end
  endtask

  // Drop then raise match so the FSM sees a fresh match edge and starts ringing.
  task automatic arm_and_ring(input string name);
    bus.current_time = 16'h0629;
    step();
    bus.current_time = 16'h0630;
    step();
    check_alarm(name, 1'b1, 2'b01);
  endtask

  logic blink_exp[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0000, 16'h2134, 16'h0000, 32'h32313334};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h21A4, 16'h0000, 32'h32314534};
    vecs[2] = '{1'b1, 1'b0, 16'h1259, 16'h2134, 16'h0000, 32'h31323539};
    vecs[3] = '{1'b1, 1'b1, 16'h0000, 16'h1111, 16'h2222, 32'h30303030};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 16'h1111, 16'h0915, 32'h30393135};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h1111, 16'hFB78, 32'h45453738};
    vecs[6] = '{1'b0, 1'b1, 16'h0000, 16'h9999, 16'h0000, 32'h39393939};

    reset                 = 1'b1;
    bus.tick              = 1'b0;
    bus.alarm_time        = 16'h0000;
    bus.current_time      = 16'h1111;
    bus.key_time          = 16'h0000;
    bus.show_a            = 1'b0;
    bus.show_current_time = 1'b1;
    bus.alarm_en          = 1'b0;
    bus.stop_alarm        = 1'b0;
    bus.snooze            = 1'b0;
    step();
    step();
    check_disp("reset_display", 32'h20202020);
    check_alarm("reset_alarm", 1'b0, 2'b00);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      bus.show_a            = vecs[i].show_a;
      bus.show_current_time = vecs[i].show_cur;
      bus.alarm_time        = vecs[i].alarm;
      bus.current_time      = vecs[i].current;
      bus.key_time          = vecs[i].key;
      step();
      check_disp($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Blink: tick every 10 cycles, phase toggles every 2 ticks.
    bus.show_a            = 1'b0;
    bus.show_current_time = 1'b0;
    bus.key_time          = 16'h0915;
    step();
    check_disp("blink_start", 32'h30393135);
    for (int k = 0; k < 6; k++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      for (int c = 0; c < 9; c++) step();
      check_disp($sformatf("blink_tick%0d", k + 1),
                 blink_exp[k] ? 32'h20202020 : 32'h30393135);
    end
    // Leaving key mode while blanked must clear the phase.
    bus.show_current_time = 1'b1;
    bus.current_time      = 16'h1111;
    step();
    step();
    bus.show_current_time = 1'b0;
    step();
    check_disp("blink_cleared", 32'h30393135);

    // Alarm ringing and auto-stop after 4 ticks.
    bus.show_current_time = 1'b1;
    bus.alarm_time        = 16'h0630;
    bus.current_time      = 16'h0629;
    bus.alarm_en          = 1'b1;
    step();
    step();
    check_alarm("armed_idle", 1'b0, 2'b00);
    bus.current_time = 16'h0630;
    step();
    check_alarm("ring_on_edge", 1'b1, 2'b01);
    for (int k = 0; k < 3; k++) pulse_tick();
    check_alarm("ring_3_ticks", 1'b1, 2'b01);
    pulse_tick();
    check_alarm("ring_timeout", 1'b0, 2'b00);
    for (int c = 0; c < 5; c++) step();
    check_alarm("match_held_no_retrigger", 1'b0, 2'b00);

    // Snooze held high stays in snooze without restarting the count.
    arm_and_ring("ring_before_snooze");
    bus.snooze = 1'b1;
    step();
    check_alarm("snooze_enter", 1'b0, 2'b10);
    pulse_tick();
    pulse_tick();
    check_alarm("snooze_2_ticks", 1'b0, 2'b10);
    bus.snooze = 1'b0;
    pulse_tick();
    check_alarm("snooze_rering", 1'b1, 2'b01);
    bus.stop_alarm = 1'b1;
    step();
    bus.stop_alarm = 1'b0;
    check_alarm("stop_from_ring", 1'b0, 2'b00);

    arm_and_ring("ring_before_both");
    bus.stop_alarm = 1'b1;
    bus.snooze     = 1'b1;
    step();
    bus.stop_alarm = 1'b0;
    bus.snooze     = 1'b0;
    check_alarm("stop_beats_snooze", 1'b0, 2'b00);

    arm_and_ring("ring_before_disable");
    bus.alarm_en = 1'b0;
    step();
    check_alarm("disable_idle", 1'b0, 2'b00);
    bus.alarm_en = 1'b1;
    step();
    step();
    check_alarm("reenable_no_edge", 1'b0, 2'b00);

    arm_and_ring("ring_before_reset");
    reset = 1'b1;
    step();
    check_alarm("reset_mid_ring", 1'b0, 2'b00);
    bus.current_time = 16'h0629;
    step();
    reset = 1'b0;
    step();
    check_alarm("after_reset_idle", 1'b0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
